// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, multiplier timing
// and the HI/LO controller state encoding.
package alu_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_OUT   = 6'b111111;

  localparam int MUL_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/hilo_cycle_cnt.sv
// Multiply iteration counter: saturates at MAX,
// tc flags the terminal count.
module hilo_cycle_cnt #(
  parameter int MAX = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [5:0] r_cnt;

  assign tc = (r_cnt == 6'(MAX));

  // count up while enabled, hold at terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 6'd0;
    end else if (clr) begin
      r_cnt <= 6'd0;
    end else if (en && !tc) begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences the multiply,
// captures the product and serves MFHI/MFLO reads.
module hilo_ctrl
  import alu_pkg::*;
#(
  parameter logic [5:0] FUNCT_MULTU = alu_pkg::FUNCT_MULTU,
  parameter logic [5:0] FUNCT_MFHI  = alu_pkg::FUNCT_MFHI,
  parameter logic [5:0] FUNCT_MFLO  = alu_pkg::FUNCT_MFLO,
  parameter int         MUL_CYCLES  = alu_pkg::MUL_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [63:0] dataIn,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  hilo_state_t r_state;
  hilo_state_t w_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_dout;

  logic w_busy;
  logic w_start;
  logic w_tc;
  logic w_load;
  logic w_rd_hi;
  logic w_rd_lo;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_start = !w_busy && (Signal == FUNCT_MULTU);
  assign w_load  = w_busy && w_tc;
  assign w_rd_hi = !w_busy && (Signal == FUNCT_MFHI);
  assign w_rd_lo = !w_busy && (Signal == FUNCT_MFLO);

  assign busy    = w_busy;
  assign done    = (r_state == ST_DONE);
  assign dataOut = r_dout;

  hilo_cycle_cnt #(
    .MAX (MUL_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start),
    .en    (w_busy),
    .tc    (w_tc)
  );

  // next-state: restart requests only count outside BUSY
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: w_next = w_start ? ST_BUSY : ST_IDLE;
      ST_DONE: w_next = w_start ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_next = w_load  ? ST_DONE : ST_BUSY;
      default: w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // capture the product at the terminal BUSY edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (w_load) begin
      r_hi <= dataIn[63:32];
      r_lo <= dataIn[31:0];
    end
  end

  // read port: one-cycle latency, held while BUSY
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= 32'h0;
    end else begin
      unique case (1'b1)
        w_rd_hi: r_dout <= r_hi;
        w_rd_lo: r_dout <= r_lo;
        default: r_dout <= r_dout;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: read-decode table
// plus directed multi-cycle sequences.
module tb_hilo_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  Signal;
  logic [63:0] dataIn;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int n_chk;
  int n_err;

  hilo_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (Signal),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sig;
    logic [31:0] exp_out;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start a multiply and run until done or timeout
  task automatic run_mult(input logic [63:0] d,
                          input logic [5:0] bsig,
                          input int restart_at,
                          input logic [31:0] hold,
                          output int n_edges,
                          output bit busy_ok,
                          output bit hold_ok);
    Signal = FUNCT_MULTU;
    dataIn = d;
    tick();
    n_edges = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n_edges < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (dataOut !== hold) hold_ok = 1'b0;
      Signal = (n_edges == restart_at) ? FUNCT_MULTU : bsig;
      tick();
      n_edges++;
    end
    Signal = 6'h00;
  endtask

  int  ne;
  bit  bok;
  bit  hok;
  int  ndone;

  initial begin
    n_chk = 0;
    n_err = 0;
    Signal = 6'h00;
    dataIn = 64'h0;
    reset = 1'b0;
    #12;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_dout", {32'h0, dataOut}, 64'h0);
    reset = 1'b1;
    tick();

    // basic multiply
    run_mult(64'h00000003_0000000C, 6'h00, -1, 32'h0,
             ne, bok, hok);
    check("basic_edges", ne, 34);
    check("basic_busy", {63'h0, bok}, 64'h1);
    check("basic_done", {63'h0, done}, 64'h1);
    check("basic_busy_in_done", {63'h0, busy}, 64'h0);
    tick();
    check("done_pulse", {63'h0, done}, 64'h0);
    check("idle_busy", {63'h0, busy}, 64'h0);

    // read decode table with HI=3, LO=C
    tbl[0] = '{FUNCT_MFHI, 32'h00000003, 1'b0};
    tbl[1] = '{FUNCT_MFLO, 32'h0000000C, 1'b0};
    tbl[2] = '{6'h3F,      32'h0000000C, 1'b0};
    tbl[3] = '{6'h00,      32'h0000000C, 1'b0};
    tbl[4] = '{FUNCT_MFHI, 32'h00000003, 1'b0};
    tbl[5] = '{6'h3F,      32'h00000003, 1'b0};
    tbl[6] = '{FUNCT_MFLO, 32'h0000000C, 1'b0};
    dataIn = 64'hDEADBEEF_CAFEF00D;
    for (int i = 0; i < 7; i++) begin
      Signal = tbl[i].sig;
      tick();
      check($sformatf("tbl%0d_dout", i),
            {32'h0, dataOut}, {32'h0, tbl[i].exp_out});
      check($sformatf("tbl%0d_busy", i),
            {63'h0, busy}, {63'h0, tbl[i].exp_busy});
    end
    Signal = 6'h00;

    // restart while busy is ignored
    run_mult(64'h00000007_00000009, 6'h00, 5, 32'h0000000C,
             ne, bok, hok);
    check("restart_edges", ne, 34);
    check("restart_busy", {63'h0, bok}, 64'h1);
    tick();

    // set dataOut to A5A5A5A5
    run_mult(64'hA5A5A5A5_5A5A5A5A, 6'h00, -1, 32'h0000000C,
             ne, bok, hok);
    tick();
    Signal = FUNCT_MFHI;
    tick();
    check("a5_dout", {32'h0, dataOut}, 64'hA5A5A5A5);

    // read while busy holds, then DONE read sees new HI
    run_mult(64'h11111111_22222222, FUNCT_MFHI, -1,
             32'hA5A5A5A5, ne, bok, hok);
    check("rwb_edges", ne, 34);
    check("rwb_hold", {63'h0, hok}, 64'h1);
    check("rwb_dout_done", {32'h0, dataOut}, 64'hA5A5A5A5);
    Signal = FUNCT_MFHI;
    tick();
    check("done_rd_hi", {32'h0, dataOut}, 64'h11111111);

    // back-to-back: MULTU issued in the DONE cycle
    Signal = FUNCT_MFLO;
    tick();
    check("pre_b2b_lo", {32'h0, dataOut}, 64'h22222222);
    run_mult(64'h00000044_00000055, 6'h00, -1, 32'h22222222,
             ne, bok, hok);
    check("b2b1_edges", ne, 34);
    dataIn = 64'h00000066_00000077;
    Signal = FUNCT_MULTU;
    tick();
    check("b2b_busy", {63'h0, busy}, 64'h1);
    check("b2b_done", {63'h0, done}, 64'h0);
    Signal = 6'h00;
    ne = 1;
    while (!done && ne < 60) begin
      tick();
      ne++;
    end
    check("b2b2_edges", ne, 34);
    Signal = FUNCT_MFHI;
    tick();
    check("b2b_hi", {32'h0, dataOut}, 64'h66);
    Signal = FUNCT_MFLO;
    tick();
    check("b2b_lo", {32'h0, dataOut}, 64'h77);

    // reset mid-multiply at counter 10
    Signal = FUNCT_MULTU;
    dataIn = 64'h12345678_9ABCDEF0;
    tick();
    Signal = 6'h00;
    repeat (10) tick();
    check("mid_busy_pre", {63'h0, busy}, 64'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_dout", {32'h0, dataOut}, 64'h0);
    #1;
    reset = 1'b1;
    Signal = FUNCT_MFHI;
    tick();
    check("mid_rd_hi", {32'h0, dataOut}, 64'h0);
    Signal = FUNCT_MFLO;
    tick();
    check("mid_rd_lo", {32'h0, dataOut}, 64'h0);
    Signal = 6'h00;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("mid_no_done", ndone, 0);
    Signal = FUNCT_MFHI;
    tick();
    check("mid_hi_after", {32'h0, dataOut}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
